ahb_refill_master: RTL and testbench

//  AHB-Lite read initiator for I-cache line refill; drives the bus that transfer_handler receives.
//  - On a miss request, issues one WRAP4 read burst, critical word first.
//  - Returns the critical word early, then the full line with an error flag.
//  - Sits between the cache miss logic and the AHB fabric/memory. Read-only: hwrite is tied 0.

---
 rtl/ahb_refill_master_pkg.sv | 30 +++
 rtl/ahb_refill_master_wrap_addr_gen.sv | 19 +
 rtl/ahb_refill_master.sv | 213 +++++++++++++++++++++
 tb/tb_ahb_refill_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_refill_master_pkg.sv
// Shared bus encodings and FSM state type for the I-cache refill master.
package ahb_refill_master_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } trans_types_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StBurst,
      StDrain,
      StDone
   } refill_state_e;

   // 2-bit add gives the WRAP4 word index for free
   function automatic logic [1:0] wrap_slot(input logic [1:0] w0, input logic [1:0] cnt);
      return w0 + cnt;
   endfunction

endpackage

// File: rtl/ahb_refill_master_wrap_addr_gen.sv
// WRAP4 index generator: next beat address for the address phase and the
// line slot for the beat currently in its data phase.
module ahb_refill_master_wrap_addr_gen
   import ahb_refill_master_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic [ADDR_W-5:0] base_i,
   input  logic [1:0]        w0_i,
   input  logic [1:0]        acnt_i,
   input  logic [1:0]        dcnt_i,
   output logic [ADDR_W-1:0] haddr_o,
   output logic [1:0]        slot_o
);

   assign haddr_o = {base_i, wrap_slot(w0_i, acnt_i), 2'b00};
   assign slot_o  = wrap_slot(w0_i, dcnt_i);

endmodule

// File: rtl/ahb_refill_master.sv
// AHB-Lite read master issuing one WRAP4 burst per I-cache miss, returning the
// critical word early and the whole address-ordered line at the end.
module ahb_refill_master
   import ahb_refill_master_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BEATS  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic [ADDR_W-1:0]       req_addr,
   output logic                    req_ready,
   output logic [ADDR_W-1:0]       haddr,
   output logic [1:0]              htrans,
   output logic                    hwrite,
   output logic [2:0]              hsize,
   output logic [2:0]              hburst,
   input  logic [DATA_W-1:0]       hrdata,
   input  logic                    hready,
   input  logic                    hresp,
   output logic                    crit_valid,
   output logic [DATA_W-1:0]       crit_data,
   output logic                    line_valid,
   output logic [ADDR_W-1:0]       line_addr,
   output logic [BEATS*DATA_W-1:0] line_data,
   output logic                    line_err
);

   refill_state_e             state_q, state_d;
   logic [ADDR_W-5:0]         base_q, base_d;
   logic [1:0]                w0_q, w0_d;
   logic [1:0]                acnt_q, acnt_d;
   logic [1:0]                dcnt_q, dcnt_d;
   logic                      err_q, err_d;
   logic                      req_ready_q, req_ready_d;
   trans_types_e              htrans_q, htrans_d;
   logic [ADDR_W-1:0]         haddr_q, haddr_d;
   logic [2:0]                hburst_q, hburst_d;
   logic                      crit_valid_q, crit_valid_d;
   logic [DATA_W-1:0]         crit_data_q, crit_data_d;
   logic                      line_valid_q, line_valid_d;
   logic [ADDR_W-1:0]         line_addr_q, line_addr_d;
   logic [BEATS*DATA_W-1:0]   line_data_q, line_data_d;
   logic                      line_err_q, line_err_d;

   logic [1:0]        acnt_inc;
   logic [ADDR_W-1:0] next_haddr;
   logic [1:0]        cap_slot;
   logic              err_cycle;
   logic              unused_req_lsbs;

   assign acnt_inc        = acnt_q + 2'd1;
   assign unused_req_lsbs = ^req_addr[1:0];

   ahb_refill_master_wrap_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_wrap_addr_gen (
      .base_i  (base_q),
      .w0_i    (w0_q),
      .acnt_i  (acnt_inc),
      .dcnt_i  (dcnt_q),
      .haddr_o (next_haddr),
      .slot_o  (cap_slot)
   );

   // First ERROR cycle: a data phase is open and the slave stalls with ERROR
   assign err_cycle = (state_q == StBurst || state_q == StDrain) && !err_q &&
                      (hresp == HRESP_ERROR) && !hready;

   always_comb begin
      state_d      = state_q;
      base_d       = base_q;
      w0_d         = w0_q;
      acnt_d       = acnt_q;
      dcnt_d       = dcnt_q;
      err_d        = err_q;
      req_ready_d  = req_ready_q;
      htrans_d     = htrans_q;
      haddr_d      = haddr_q;
      hburst_d     = hburst_q;
      crit_valid_d = 1'b0;
      crit_data_d  = crit_data_q;
      line_valid_d = 1'b0;
      line_addr_d  = line_addr_q;
      line_data_d  = line_data_q;
      line_err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d     = StAddr;
               base_d      = req_addr[ADDR_W-1:4];
               w0_d        = req_addr[3:2];
               acnt_d      = 2'd0;
               dcnt_d      = 2'd0;
               err_d       = 1'b0;
               req_ready_d = 1'b0;
               htrans_d    = TRANS_NONSEQ;
               haddr_d     = {req_addr[ADDR_W-1:2], 2'b00};
               hburst_d    = HBURST_WRAP4;
               line_addr_d = {req_addr[ADDR_W-1:4], 4'b0000};
            end
         end
         StAddr: begin
            if (hready) begin
               state_d  = StBurst;
               acnt_d   = acnt_inc;
               htrans_d = TRANS_SEQ;
               haddr_d  = next_haddr;
            end
         end
         StBurst: begin
            if (err_cycle) begin
               state_d  = StDrain;
               err_d    = 1'b1;
               htrans_d = TRANS_IDLE;
               hburst_d = HBURST_SINGLE;
            end else if (hready) begin
               line_data_d[32'(cap_slot) * DATA_W +: DATA_W] = hrdata;
               if (dcnt_q == 2'd0) begin
                  crit_valid_d = 1'b1;
                  crit_data_d  = hrdata;
               end
               dcnt_d = dcnt_q + 2'd1;
               if (acnt_q == 2'd3) begin
                  state_d  = StDrain;
                  htrans_d = TRANS_IDLE;
                  hburst_d = HBURST_SINGLE;
               end else begin
                  acnt_d  = acnt_inc;
                  haddr_d = next_haddr;
               end
            end
         end
         StDrain: begin
            if (err_cycle) begin
               err_d = 1'b1;
            end else if (hready) begin
               if (!err_q) begin
                  line_data_d[32'(cap_slot) * DATA_W +: DATA_W] = hrdata;
               end
               state_d      = StDone;
               line_valid_d = 1'b1;
               line_err_d   = err_q;
            end
         end
         StDone: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
            htrans_d    = TRANS_IDLE;
            hburst_d    = HBURST_SINGLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         base_q       <= '0;
         w0_q         <= 2'd0;
         acnt_q       <= 2'd0;
         dcnt_q       <= 2'd0;
         err_q        <= 1'b0;
         req_ready_q  <= 1'b1;
         htrans_q     <= TRANS_IDLE;
         haddr_q      <= '0;
         hburst_q     <= HBURST_SINGLE;
         crit_valid_q <= 1'b0;
         crit_data_q  <= '0;
         line_valid_q <= 1'b0;
         line_addr_q  <= '0;
         line_data_q  <= '0;
         line_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         base_q       <= base_d;
         w0_q         <= w0_d;
         acnt_q       <= acnt_d;
         dcnt_q       <= dcnt_d;
         err_q        <= err_d;
         req_ready_q  <= req_ready_d;
         htrans_q     <= htrans_d;
         haddr_q      <= haddr_d;
         hburst_q     <= hburst_d;
         crit_valid_q <= crit_valid_d;
         crit_data_q  <= crit_data_d;
         line_valid_q <= line_valid_d;
         line_addr_q  <= line_addr_d;
         line_data_q  <= line_data_d;
         line_err_q   <= line_err_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign haddr      = haddr_q;
   assign htrans     = err_cycle ? TRANS_IDLE : htrans_q;
   assign hwrite     = 1'b0;
   assign hsize      = HSIZE_WORD;
   assign hburst     = hburst_q;
   assign crit_valid = crit_valid_q;
   assign crit_data  = crit_data_q;
   assign line_valid = line_valid_q;
   assign line_addr  = line_addr_q;
   assign line_data  = line_data_q;
   assign line_err   = line_err_q;

endmodule

// File: tb/tb_ahb_refill_master.sv
// Bench for ahb_refill_master: the bench acts as the AHB slave and keeps an
// address-ordered model of the cache line built from the beats it delivered.
module tb_ahb_refill_master;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BEATS  = 4;
   localparam logic [1:0] T_IDLE = 2'b00, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    req_valid;
   logic [ADDR_W-1:0]       req_addr;
   logic                    req_ready;
   logic [ADDR_W-1:0]       haddr;
   logic [1:0]              htrans;
   logic                    hwrite;
   logic [2:0]              hsize;
   logic [2:0]              hburst;
   logic [DATA_W-1:0]       hrdata;
   logic                    hready;
   logic                    hresp;
   logic                    crit_valid;
   logic [DATA_W-1:0]       crit_data;
   logic                    line_valid;
   logic [ADDR_W-1:0]       line_addr;
   logic [BEATS*DATA_W-1:0] line_data;
   logic                    line_err;

   always #5 clk = ~clk;

   ahb_refill_master #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .BEATS  (BEATS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .haddr      (haddr),
      .htrans     (htrans),
      .hwrite     (hwrite),
      .hsize      (hsize),
      .hburst     (hburst),
      .hrdata     (hrdata),
      .hready     (hready),
      .hresp      (hresp),
      .crit_valid (crit_valid),
      .crit_data  (crit_data),
      .line_valid (line_valid),
      .line_addr  (line_addr),
      .line_data  (line_data),
      .line_err   (line_err)
   );

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] model_line [4];
   int          wait_plan [4];
   logic [31:0] data_base;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [127:0] model_vec();
      return {model_line[3], model_line[2], model_line[1], model_line[0]};
   endfunction

   // One refill transaction; beat k of the burst returns data_base + k.
   task automatic refill(input logic [31:0] addr, input int err_beat, input bit keep_valid,
                         input string tag);
      logic [31:0] got_addr[$];
      int          n_acc, n_nonseq, waits_total, crit_cnt;
      int          t_acc, t_line, t_crit, t_beat0, dp_beat, wait_left, n_exp;
      bit          dp_valid, done, prev_stall, err_phase, err_first;
      logic [1:0]  htrans_s, prev_htrans, slot;
      logic [31:0] haddr_s, prev_haddr, crit_s, laddr_s, exp_a;
      logic [2:0]  hburst_s;
      logic        hready_s, ready_s, valid_s, lerr_s;
      logic [127:0] line_s;
      n_acc = 0; n_nonseq = 0; waits_total = 0; crit_cnt = 0;
      t_acc = -1; t_line = -1; t_crit = -1; t_beat0 = -1; dp_beat = 0; wait_left = 0;
      dp_valid = 0; done = 0; prev_stall = 0; err_phase = 0;
      prev_htrans = 0; prev_haddr = 0; crit_s = 0; laddr_s = 0; lerr_s = 0; line_s = 0;
      req_valid = 1'b1;
      req_addr  = addr;
      for (int c = 0; c < 60 && !done; c++) begin
         hresp = 1'b0; hready = 1'b1; hrdata = $urandom; err_first = 0;
         if (dp_valid) begin
            hrdata = data_base + 32'(dp_beat);
            if (dp_beat == err_beat) begin
               hresp = 1'b1; hready = err_phase; err_first = !err_phase;
            end else if (wait_left > 0) begin
               hready = 1'b0;
            end
         end
         #1;
         htrans_s = htrans; haddr_s = haddr; hburst_s = hburst;
         hready_s = hready; ready_s = req_ready; valid_s = req_valid;
         if (c == 0) begin
            check({tag, " req_ready idle"}, req_ready, 1'b1);
            check({tag, " line_valid idle"}, line_valid, 1'b0);
         end
         if (err_first) begin
            check({tag, " htrans cancel on error"}, htrans_s, T_IDLE);
         end else if (prev_stall) begin
            check({tag, " htrans held"}, htrans_s, prev_htrans);
            check({tag, " haddr held"}, haddr_s, prev_haddr);
         end
         if (hready_s && (htrans_s == T_NONSEQ || htrans_s == T_SEQ)) begin
            check({tag, " hburst"}, hburst_s, 3'b010);
            check({tag, " htrans kind"}, htrans_s, (n_acc == 0) ? T_NONSEQ : T_SEQ);
         end
         if (crit_valid) begin
            crit_cnt++; t_crit = c; crit_s = crit_data;
         end
         if (line_valid) begin
            t_line = c; line_s = line_data; laddr_s = line_addr; lerr_s = line_err; done = 1;
         end
         @(posedge clk); #1;
         if (valid_s && ready_s && t_acc < 0) begin
            t_acc = c;
            if (!keep_valid) req_valid = 1'b0;
         end
         if (dp_valid) begin
            if (hready_s) begin
               if (dp_beat != err_beat) begin
                  slot = addr[3:2] + 2'(dp_beat);
                  model_line[slot] = data_base + 32'(dp_beat);
                  if (dp_beat == 0) t_beat0 = c;
               end
               dp_valid = 0;
            end else if (dp_beat == err_beat) begin
               err_phase = 1;
            end else begin
               wait_left--; waits_total++;
            end
         end
         if (hready_s && (htrans_s == T_NONSEQ || htrans_s == T_SEQ)) begin
            got_addr.push_back(haddr_s);
            if (htrans_s == T_NONSEQ) n_nonseq++;
            dp_valid = 1; dp_beat = n_acc; n_acc++; err_phase = 0;
            wait_left = (dp_beat < 4) ? wait_plan[dp_beat] : 0;
         end
         prev_stall = !hready_s; prev_htrans = htrans_s; prev_haddr = haddr_s;
      end
      check({tag, " accepted"}, t_acc >= 0, 1'b1);
      check({tag, " line_valid seen"}, done, 1'b1);
      n_exp = (err_beat >= 0) ? err_beat + 1 : 4;
      check({tag, " address count"}, got_addr.size(), n_exp);
      for (int k = 0; k < n_exp && k < got_addr.size(); k++) begin
         exp_a = {addr[31:4], 4'b0000} + 32'(((int'(addr[3:2]) + k) % 4) * 4);
         check($sformatf("%s haddr beat %0d", tag, k), got_addr[k], exp_a);
      end
      check({tag, " single nonseq"}, n_nonseq, 1);
      check({tag, " line_addr"}, laddr_s, {addr[31:4], 4'b0000});
      check({tag, " line_data"}, line_s, model_vec());
      check({tag, " line_err"}, lerr_s, err_beat >= 0);
      check({tag, " crit pulses"}, crit_cnt, (err_beat == 0) ? 0 : 1);
      if (err_beat != 0) begin
         check({tag, " crit_data"}, crit_s, data_base);
         check({tag, " crit timing"}, t_crit, t_beat0 + 1);
      end
      if (err_beat < 0) check({tag, " latency"}, t_line - t_acc, 6 + waits_total);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
      data_base = 0;
      for (int i = 0; i < 4; i++) begin
         model_line[i] = '0; wait_plan[i] = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("reset req_ready", req_ready, 1'b1);
      check("reset htrans", htrans, T_IDLE);
      check("reset haddr", haddr, 32'h0);
      check("reset hburst", hburst, 3'b000);
      check("reset hsize/hwrite", {hsize, hwrite}, {3'b010, 1'b0});
      check("reset pulses", {crit_valid, line_valid, line_err}, 3'b000);
      check("reset line_data", line_data, 128'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      data_base = 32'hA0;
      refill(32'h0000_1000, -1, 1'b0, "aligned");
      data_base = $urandom;
      refill(32'h0000_2008, -1, 1'b0, "wrap");
      check("wrap slot2 first beat", line_data[64 +: 32], data_base);

      data_base = $urandom;
      wait_plan[1] = 2;
      refill(32'h0000_3004, -1, 1'b0, "waits");
      wait_plan[1] = 0;

      data_base = $urandom;
      refill(32'h0000_4000, 2, 1'b0, "err beat2");
      data_base = $urandom;
      refill(32'h0000_4808, 0, 1'b0, "err beat0");

      data_base = $urandom;
      refill(32'h0000_5004, -1, 1'b1, "b2b first");
      data_base = $urandom;
      refill(32'h0000_600C, -1, 1'b0, "b2b second");

      for (int r = 0; r < 8; r++) begin
         int eb;
         data_base = $urandom;
         for (int i = 0; i < 4; i++) wait_plan[i] = $urandom_range(0, 2);
         eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         refill($urandom, eb, 1'b0, $sformatf("rand%0d", r));
      end
      for (int i = 0; i < 4; i++) wait_plan[i] = 0;

      // Reset while the burst is in flight
      req_valid = 1'b1; req_addr = 32'h0000_7000; hready = 1'b1; hresp = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midburst seq active", htrans, T_SEQ);
      rst = 1'b1;
      #1;
      check("midburst reset htrans", htrans, T_IDLE);
      check("midburst reset req_ready", req_ready, 1'b1);
      check("midburst reset hburst", hburst, 3'b000);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #4;
         check($sformatf("post reset no line_valid %0d", i), line_valid, 1'b0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) model_line[i] = '0;

      data_base = $urandom;
      refill(32'h0000_8008, 1, 1'b0, "after reset err beat1");
      data_base = $urandom;
      refill(32'h0000_9004, -1, 1'b0, "after reset clean");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
